// File: rtl/nn_cfg_loader.sv
// ---------------------------------------------------------------------------
// nn_cfg_loader
//   Host-side transmitter for the accelerator config bus. Per-layer commands
//   are queued in a small FIFO. Each command is replayed as a burst of masked
//   register writes on cfg/cfg_addr/cfg_wr_en in ascending address order,
//   followed by a one-cycle start pulse. The block then waits for the layer
//   done pulse before launching the next queued command.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_cmd_valid  host command valid
//   o_cmd_ready  FIFO can accept a command (not full)
//   i_cmd_data   CFG_NUM words, word k = bits[k*CFG_WIDTH +: CFG_WIDTH]
//   i_cmd_mask   bit k set: write word k to config address k
//   o_cfg        config write data (holds last value between writes)
//   o_cfg_addr   config write address (holds last value between writes)
//   o_cfg_wr_en  config write strobe, one write per high cycle
//   o_start      one-cycle layer start pulse
//   i_done       layer-complete pulse, only honoured while waiting for it
//   o_busy       a layer is in flight or the FIFO holds commands
//   o_layer_cnt  number of completed layers, wraps 255 -> 0
// ---------------------------------------------------------------------------
module nn_cfg_loader #(
    parameter int CFG_WIDTH      = 16,
    parameter int CFG_ADDR_WIDTH = 2,
    parameter int CFG_NUM        = 4,
    parameter int DEPTH          = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [CFG_NUM*CFG_WIDTH-1:0]  i_cmd_data,
    input  logic [CFG_NUM-1:0]            i_cmd_mask,
    output logic [CFG_WIDTH-1:0]          o_cfg,
    output logic [CFG_ADDR_WIDTH-1:0]     o_cfg_addr,
    output logic                          o_cfg_wr_en,
    output logic                          o_start,
    input  logic                          i_done,
    output logic                          o_busy,
    output logic [7:0]                    o_layer_cnt
);

    localparam int DATA_W = CFG_NUM * CFG_WIDTH;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Index of the lowest set bit; the caller guarantees the mask is non-zero.
    function automatic logic [CFG_ADDR_WIDTH-1:0] lowest_idx(input logic [CFG_NUM-1:0] m);
        logic [CFG_ADDR_WIDTH-1:0] idx;
        idx = '0;
        for (int i = CFG_NUM - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = CFG_ADDR_WIDTH'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Select config word k out of a packed command.
    function automatic logic [CFG_WIDTH-1:0] pick_word(input logic [DATA_W-1:0] d,
                                                      input logic [CFG_ADDR_WIDTH-1:0] k);
        logic [CFG_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < CFG_NUM; i++) begin
            if (k == CFG_ADDR_WIDTH'(i)) begin
                w = d[i*CFG_WIDTH +: CFG_WIDTH];
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    state_t                      state_q, state_d;
    logic [DATA_W-1:0]           fifo_data_q [DEPTH];
    logic [DATA_W-1:0]           fifo_data_d [DEPTH];
    logic [CFG_NUM-1:0]          fifo_mask_q [DEPTH];
    logic [CFG_NUM-1:0]          fifo_mask_d [DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [DATA_W-1:0]           data_sh_q, data_sh_d;
    logic [CFG_NUM-1:0]          pend_q, pend_d;
    logic [CFG_WIDTH-1:0]        cfg_q, cfg_d;
    logic [CFG_ADDR_WIDTH-1:0]   cfg_addr_q, cfg_addr_d;
    logic                        cfg_wr_en_q, cfg_wr_en_d;
    logic                        start_q, start_d;
    logic                        busy_q, busy_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic [7:0]                  layer_cnt_q, layer_cnt_d;
    logic                        push_s;
    logic                        pop_s;
    logic [CFG_ADDR_WIDTH-1:0]   k_s;

    // Ready is a registered view of the FIFO level, so valid never feeds it.
    assign push_s = i_cmd_valid & cmd_ready_q;
    assign k_s    = lowest_idx(pend_q);

    // Sequencer: pops one command, replays its masked writes, starts, waits for done.
    always_comb begin
        state_d     = state_q;
        pop_s       = 1'b0;
        data_sh_d   = data_sh_q;
        pend_d      = pend_q;
        cfg_d       = cfg_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wr_en_d = 1'b0;
        start_d     = 1'b0;
        layer_cnt_d = layer_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop_s     = 1'b1;
                    data_sh_d = fifo_data_q[rd_ptr_q];
                    pend_d    = fifo_mask_q[rd_ptr_q];
                    // An all-zero mask skips straight to the start pulse.
                    state_d   = (fifo_mask_q[rd_ptr_q] != '0) ? ST_WRITE : ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                cfg_wr_en_d = 1'b1;
                cfg_addr_d  = k_s;
                cfg_d       = pick_word(data_sh_q, k_s);
                // Drop the lowest pending bit; skipped indices cost no cycles.
                pend_d      = pend_q & (pend_q - 1'b1);
                if ((pend_q & (pend_q - 1'b1)) == '0) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_START: begin
                start_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_done) begin
                    layer_cnt_d = layer_cnt_q + 8'd1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command FIFO next-state: storage, pointers and fill level.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_mask_d = fifo_mask_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push_s) begin
            fifo_data_d[wr_ptr_q] = i_cmd_data;
            fifo_mask_d[wr_ptr_q] = i_cmd_mask;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        cmd_ready_d = (count_d != CNT_W'(DEPTH));
        busy_d      = (state_d != ST_IDLE) || (count_d != '0);
    end

    // FIFO storage and pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_mask_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_data_q <= fifo_data_d;
            fifo_mask_q <= fifo_mask_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Sequencer state, shadow command and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            data_sh_q   <= '0;
            pend_q      <= '0;
            cfg_q       <= '0;
            cfg_addr_q  <= '0;
            cfg_wr_en_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            layer_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            data_sh_q   <= data_sh_d;
            pend_q      <= pend_d;
            cfg_q       <= cfg_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wr_en_q <= cfg_wr_en_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            layer_cnt_q <= layer_cnt_d;
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_cfg       = cfg_q;
    assign o_cfg_addr  = cfg_addr_q;
    assign o_cfg_wr_en = cfg_wr_en_q;
    assign o_start     = start_q;
    assign o_busy      = busy_q;
    assign o_layer_cnt = layer_cnt_q;

endmodule

// File: tb/tb_nn_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_nn_cfg_loader
//   Directed bench for nn_cfg_loader. A transaction-level model (command
//   queue expanded into a timeline of expected output beats) is compared
//   against every DUT output on every falling clock edge; hand-computed
//   literal expectations pin the model for each scenario.
// ---------------------------------------------------------------------------
module tb_nn_cfg_loader;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [63:0] cmd_data = 64'd0;
    logic [3:0]  cmd_mask = 4'd0;
    logic        done = 1'b0;
    logic        o_cmd_ready;
    logic [15:0] o_cfg;
    logic [1:0]  o_cfg_addr;
    logic        o_cfg_wr_en;
    logic        o_start;
    logic        o_busy;
    logic [7:0]  o_layer_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    nn_cfg_loader #(
        .CFG_WIDTH(16), .CFG_ADDR_WIDTH(2), .CFG_NUM(4), .DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_data(cmd_data), .i_cmd_mask(cmd_mask),
        .o_cfg(o_cfg), .o_cfg_addr(o_cfg_addr), .o_cfg_wr_en(o_cfg_wr_en),
        .o_start(o_start), .i_done(done),
        .o_busy(o_busy), .o_layer_cnt(o_layer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {logic [63:0] data; logic [3:0] mask;} cmd_t;
    typedef struct {logic wr; logic [1:0] addr; logic [15:0] data; logic st;} beat_t;

    cmd_t        m_cmds[$];
    beat_t       m_beats[$];
    logic        m_idle, m_waiting, m_ready, m_busy, m_wr, m_st;
    logic [15:0] m_cfg;
    logic [1:0]  m_addr;
    logic [7:0]  m_cnt;

    task automatic model_reset();
        m_cmds.delete();
        m_beats.delete();
        m_idle = 1'b1; m_waiting = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
        m_wr = 1'b0; m_st = 1'b0; m_cfg = 16'd0; m_addr = 2'd0; m_cnt = 8'd0;
    endtask

    task automatic model_step();
        logic  idle_pre;
        logic  push_ok;
        cmd_t  c;
        beat_t b;
        idle_pre = m_idle;
        push_ok  = cmd_valid && m_ready;
        if (m_waiting && done) begin
            m_cnt     = m_cnt + 8'd1;
            m_waiting = 1'b0;
            m_idle    = 1'b1;
        end
        m_wr = 1'b0;
        m_st = 1'b0;
        if (m_beats.size() > 0) begin
            b = m_beats.pop_front();
            m_wr = b.wr;
            m_st = b.st;
            if (b.wr) begin
                m_addr = b.addr;
                m_cfg  = b.data;
            end
            if (b.st) m_waiting = 1'b1;
        end
        if (idle_pre && m_cmds.size() > 0) begin
            c = m_cmds.pop_front();
            for (int k = 0; k < 4; k++) begin
                if (c.mask[k]) m_beats.push_back('{1'b1, 2'(k), c.data[k*16 +: 16], 1'b0});
            end
            m_beats.push_back('{1'b0, 2'd0, 16'd0, 1'b1});
            m_idle = 1'b0;
        end
        if (push_ok) m_cmds.push_back('{cmd_data, cmd_mask});
        m_ready = (m_cmds.size() < DEPTH);
        m_busy  = !m_idle || (m_cmds.size() > 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("cfg_wr_en", 64'(o_cfg_wr_en), 64'(m_wr));
            chk("start",     64'(o_start),     64'(m_st));
            chk("cfg",       64'(o_cfg),       64'(m_cfg));
            chk("cfg_addr",  64'(o_cfg_addr),  64'(m_addr));
            chk("cmd_ready", 64'(o_cmd_ready), 64'(m_ready));
            chk("busy",      64'(o_busy),      64'(m_busy));
            chk("layer_cnt", 64'(o_layer_cnt), 64'(m_cnt));
        end
    end

    // Observed write / start log for the literal checks.
    typedef struct {int cyc; logic [1:0] addr; logic [15:0] data;} wlog_t;
    wlog_t wr_log[$];
    int    start_cyc  = -1;
    int    start_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (o_cfg_wr_en === 1'b1) wr_log.push_back('{cyc, o_cfg_addr, o_cfg});
            if (o_start === 1'b1) begin
                start_cyc = cyc;
                start_seen++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [63:0] d, input logic [3:0] m, output int pc);
        bit got;
        got = 1'b0;
        cmd_valid = 1'b1; cmd_data = d; cmd_mask = m;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = o_cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        pc = cyc;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL push_timeout: actual=not accepted required=accepted");
        end
    endtask

    task automatic wait_start(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (o_start === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL start_timeout: actual=no start required=start within %0d cycles", budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(output int dc);
        done = 1'b1;
        @(posedge clk);
        #1;
        dc = cyc;
        done = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_log.delete();
        start_seen = 0;
        @(posedge clk); #1;
    endtask

    logic [15:0] t1_data [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] t4_data [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};

    initial begin
        int pc, dc, pc4, dc4;
        bit found;

        // ---- reset state ----
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",     64'(o_cmd_ready), 64'd0);
        chk("rst_busy",      64'(o_busy),      64'd0);
        chk("rst_layer_cnt", 64'(o_layer_cnt), 64'd0);
        chk("rst_wr_en",     64'(o_cfg_wr_en), 64'd0);
        chk("rst_start",     64'(o_start),     64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(o_cmd_ready), 64'd1);

        // ---- 1: full mask ----
        wr_log.delete();
        push(64'h4444_3333_2222_1111, 4'b1111, pc);
        wait_start(40);
        chk("t1_nwrites", 64'(wr_log.size()), 64'd4);
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_addr", 64'(wr_log[i].addr), 64'(i));
                chk("t1_data", 64'(wr_log[i].data), 64'(t1_data[i]));
                chk("t1_wr_cycle", 64'(wr_log[i].cyc), 64'(pc + 2 + i));
            end
            chk("t1_start_cycle", 64'(start_cyc), 64'(pc + 6));
        end
        repeat (2) @(posedge clk);
        #1;
        pulse_done(dc);
        @(negedge clk);
        chk("t1_layer_cnt", 64'(o_layer_cnt), 64'd1);
        @(posedge clk); #1;

        // ---- 2: sparse mask ----
        wr_log.delete();
        push(64'hD3D3_C2C2_B1B1_A0A0, 4'b0101, pc);
        wait_start(40);
        chk("t2_nwrites", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() == 2) begin
            chk("t2_addr0", 64'(wr_log[0].addr), 64'd0);
            chk("t2_data0", 64'(wr_log[0].data), 64'hA0A0);
            chk("t2_addr1", 64'(wr_log[1].addr), 64'd2);
            chk("t2_data1", 64'(wr_log[1].data), 64'hC2C2);
            chk("t2_b2b",   64'(wr_log[1].cyc),  64'(wr_log[0].cyc + 1));
            chk("t2_start_cycle", 64'(start_cyc), 64'(wr_log[1].cyc + 1));
        end
        pulse_done(dc);
        @(negedge clk);
        chk("t2_layer_cnt", 64'(o_layer_cnt), 64'd2);
        @(posedge clk); #1;

        // ---- 3: empty mask ----
        wr_log.delete();
        push(64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, pc);
        wait_start(40);
        chk("t3_nwrites", 64'(wr_log.size()), 64'd0);
        chk("t3_start_cycle", 64'(start_cyc), 64'(pc + 2));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t3_busy_waiting", 64'(o_busy), 64'd1);
        @(posedge clk); #1;
        pulse_done(dc);
        @(negedge clk);
        chk("t3_busy_after", 64'(o_busy), 64'd0);
        chk("t3_layer_cnt", 64'(o_layer_cnt), 64'd3);

        // ---- 4: FIFO full while a layer waits ----
        reset_dut();
        push(64'h0000_0000_0000_0001, 4'b0001, pc);
        wait_start(40);
        push(64'h0000_0000_0000_0002, 4'b0001, pc);
        push(64'h0000_0000_0000_0003, 4'b0001, pc);
        @(negedge clk);
        chk("t4_ready_full", 64'(o_cmd_ready), 64'd0);
        fork
            push(64'h0000_0000_0000_0004, 4'b0001, pc4);
            begin
                repeat (4) @(posedge clk);
                #1;
                pulse_done(dc4);
            end
        join
        chk("t4_held_accept_cycle", 64'(pc4), 64'(dc4 + 2));
        for (int i = 0; i < 3; i++) begin
            wait_start(40);
            pulse_done(dc);
        end
        @(negedge clk);
        chk("t4_layer_cnt", 64'(o_layer_cnt), 64'd4);
        chk("t4_nwrites", 64'(wr_log.size()), 64'd4);
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t4_order", 64'(wr_log[i].data), 64'(t4_data[i]));
        end
        @(posedge clk); #1;

        // ---- 5: reset mid-burst ----
        reset_dut();
        push(64'h8888_7777_6666_5555, 4'b1111, pc);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (o_cfg_wr_en === 1'b1 && o_cfg_addr === 2'd1) found = 1'b1;
        end
        chk("t5_second_write_seen", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_wr_en_now", 64'(o_cfg_wr_en), 64'd0);
        chk("t5_cfg_now",   64'(o_cfg),       64'd0);
        chk("t5_addr_now",  64'(o_cfg_addr),  64'd0);
        chk("t5_start_now", 64'(o_start),     64'd0);
        chk("t5_busy_now",  64'(o_busy),      64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_log.delete();
        start_seen = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_writes", 64'(wr_log.size()), 64'd0);
        chk("t5_no_start",  64'(start_seen),    64'd0);
        chk("t5_fifo_empty", 64'(o_busy),       64'd0);
        chk("t5_layer_cnt", 64'(o_layer_cnt),   64'd0);

        // ---- 6: stray done, then wrap ----
        reset_dut();
        pulse_done(dc);
        @(negedge clk);
        chk("t6_done_idle", 64'(o_layer_cnt), 64'd0);
        @(posedge clk); #1;
        push(64'h4444_3333_2222_1111, 4'b1111, pc);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (o_cfg_wr_en === 1'b1 && o_cfg_addr === 2'd2) found = 1'b1;
        end
        chk("t6_third_write_seen", 64'(found), 64'd1);
        done = 1'b1;              // sampled in WRITE, then in START
        repeat (2) @(posedge clk);
        #1;
        done = 1'b0;
        @(negedge clk);
        chk("t6_start_now", 64'(o_start), 64'd1);
        chk("t6_done_write_start", 64'(o_layer_cnt), 64'd0);
        @(posedge clk); #1;
        pulse_done(dc);
        @(negedge clk);
        chk("t6_done_wait", 64'(o_layer_cnt), 64'd1);

        reset_dut();
        for (int i = 0; i < 256; i++) begin
            push(64'(i), 4'b0000, pc);
            wait_start(40);
            pulse_done(dc);
            if (i == 254) chk("t6_cnt_255", 64'(o_layer_cnt), 64'd255);
        end
        @(negedge clk);
        chk("t6_cnt_wrap", 64'(o_layer_cnt), 64'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
